// File: rtl/spi_master_multi_if.sv
// Bus bundle for spi_master_multi: request/config inputs, status outputs and SPI pins.
// The master modport is the controller's view and the slave modport is the front end's view.
interface spi_master_multi_if #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 12,
    parameter int SEL_W  = 4,
    parameter int DIV_W  = 16
) ();
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [SEL_W-1:0]  ss_sel;
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  div;
    logic              hold_ss;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NUM_SS-1:0] ss_n;

    modport master (
        input  start, tx_data, ss_sel, cpol, cpha, div, hold_ss, miso,
        output busy, done, rx_data, sclk, mosi, ss_n
    );

    modport slave (
        output start, tx_data, ss_sel, cpol, cpha, div, hold_ss, miso,
        input  busy, done, rx_data, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: one MSB-first word per start, all CPOL/CPHA modes,
// runtime half-period divider and optional slave-select hold across words.
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 12,
    parameter int SEL_W  = 4,
    parameter int DIV_W  = 16
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    spi_master_multi_if.master bus
);
    localparam int HC_W = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_SS-1:0] v;
        for (int i = 0; i < NUM_SS; i++) begin
            v[i] = (sel != SEL_W'(i));
        end
        return v;
    endfunction

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, hold_q, hold_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
    logic              tick_s, edge_s, lead_s;

    // State register and all datapath/output flops.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            hcnt_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            ss_n_q    <= '1;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            hold_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            hcnt_q    <= hcnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            ss_n_q    <= ss_n_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            hold_q    <= hold_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, divider, SCLK edge generation and shift/sample datapath.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        hcnt_d    = hcnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        ss_n_d    = ss_n_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        hold_d    = hold_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        edge_s    = 1'b0;
        lead_s    = 1'b0;
        // Equality compare against the latched divider means div=all 1s cannot wrap.
        tick_s    = (cnt_q == div_q);
        cnt_d     = tick_s ? '0 : cnt_q + DIV_W'(1);

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                sclk_d = cpol_q;
                if (bus.start) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    div_d   = bus.div;
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    hold_d  = bus.hold_ss;
                    sclk_d  = bus.cpol;
                    rx_sh_d = '0;
                    ss_n_d  = ss_decode(bus.ss_sel);
                    // Leading-edge sampling needs the MSB on the wire before the first edge.
                    if (!bus.cpha) begin
                        mosi_d  = bus.tx_data[DATA_W-1];
                        tx_sh_d = bus.tx_data << 1;
                    end else begin
                        tx_sh_d = bus.tx_data;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (tick_s) begin
                    state_d = XFER;
                    hcnt_d  = '0;
                    sclk_d  = ~sclk_q;
                    edge_s  = 1'b1;
                    lead_s  = 1'b1;
                end else begin
                    state_d = SETUP;
                end
            end
            XFER: begin
                // The last half ends without a toggle: SCLK is already back at CPOL.
                if (tick_s && (hcnt_q == HC_W'(2 * DATA_W - 1))) begin
                    state_d = HOLD;
                end else if (tick_s) begin
                    hcnt_d  = hcnt_q + HC_W'(1);
                    sclk_d  = ~sclk_q;
                    edge_s  = 1'b1;
                    lead_s  = hcnt_q[0];
                end else begin
                    state_d = XFER;
                end
            end
            HOLD: begin
                if (tick_s) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    ss_n_d    = hold_q ? ss_n_q : '1;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Sampling edge is leading for cpha=0 and trailing for cpha=1; the other one shifts.
        if (edge_s && (lead_s ^ cpha_q)) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.miso};
        end else if (edge_s) begin
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = tx_sh_q << 1;
        end else begin
            rx_sh_d = rx_sh_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.ss_n    = ss_n_q;
endmodule
